rptr_empty: RTL and testbench

- Read-side pointer and empty-flag stage of the dual-clock FIFO; the read-domain counterpart of the write pointer/full stage.
- Takes the write pointer after it has been synchronized into the read domain (Gray code).
- Produces the read address into the FIFO memory and the Gray read pointer that is sent to the write domain.
- Produces the registered empty flag, a registered fill level and an almost-empty flag.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_gray2bin.sv | 13 +
 rtl/rptr_empty.sv | 92 +++++++++
 tb/tb_rptr_empty.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and default sizing.
package fifo_pkg;

  localparam int unsigned ADDRSIZE_DEF = 4;
  localparam int unsigned CODE_W       = 32;

  typedef logic [CODE_W-1:0] code_t;

  // Conversions operate on zero-extended words, so callers of any width up to
  // CODE_W simply widen the argument and truncate the result.
  function automatic code_t bin2gray(input code_t b);
    return (b >> 1) ^ b;
  endfunction

  function automatic code_t gray2bin(input code_t g);
    code_t b;
    b = '0;
    for (int i = 0; i < int'(CODE_W); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter, shared by the read and write pointer stages.
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = ADDRSIZE_DEF + 1
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin_c
);

  assign bin_c = WIDTH'(gray2bin(code_t'(gray)));

endmodule

// File: rtl/rptr_empty.sv
// Read-side pointer, empty flag, fill level and almost-empty flag of the dual-clock FIFO.
// Optional sticky underflow error (rerr/rerr_clr) is enabled by defining RPTR_UFLOW_EN.
module rptr_empty
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE  = ADDRSIZE_DEF,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
`ifdef RPTR_UFLOW_EN
  input  logic                rerr_clr,
  output logic                rerr,
`endif
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                ralmost_empty
);

  localparam int unsigned PTR_W = ADDRSIZE + 1;
  localparam int unsigned DEPTH = 1 << ADDRSIZE;

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbin_next_c;
  logic [PTR_W-1:0] rgray_next_c;
  logic [PTR_W-1:0] wbin_s_c;
  logic [PTR_W-1:0] diff_c;
  logic [PTR_W-1:0] level_next_c;
  logic             rd_ok_c;
  logic             empty_next_c;
  logic             ae_next_c;

  fifo_gray2bin #(
    .WIDTH (PTR_W)
  ) u_wptr_g2b (
    .gray  (rq2_wptr),
    .bin_c (wbin_s_c)
  );

  // Next-state: flags are derived from the next pointer so they never lag a read.
  always_comb begin
    rd_ok_c      = rinc & ~rempty;
    rbin_next_c  = rbin + PTR_W'(rd_ok_c);
    rgray_next_c = PTR_W'(bin2gray(code_t'(rbin_next_c)));
    empty_next_c = (rgray_next_c == rq2_wptr);
    diff_c       = wbin_s_c - rbin_next_c;
    level_next_c = (diff_c > PTR_W'(DEPTH)) ? PTR_W'(DEPTH) : diff_c;
    ae_next_c    = (level_next_c <= PTR_W'(AE_THRESH));
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rbin          <= rbin_next_c;
      rptr          <= rgray_next_c;
      rempty        <= empty_next_c;
      rlevel        <= level_next_c;
      ralmost_empty <= ae_next_c;
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];

`ifdef RPTR_UFLOW_EN
  logic uflow_c;

  // Sticky underflow; a new underflow outranks a clear in the same cycle.
  always_comb begin
    uflow_c = rinc & rempty;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rerr <= 1'b0;
    end else if (uflow_c) begin
      rerr <= 1'b1;
    end else if (rerr_clr) begin
      rerr <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Self-checking bench for rptr_empty (ADDRSIZE=4, AE_THRESH=2): vector table,
// directed corner sequences and randomized traffic against an occupancy model.
module tb_rptr_empty;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AE    = 2;

  logic          rclk;
  logic          rrst;
  logic          rinc;
  logic [AW:0]   rq2_wptr;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic [AW:0]   rlevel;
  logic          ralmost_empty;
`ifdef RPTR_UFLOW_EN
  logic          rerr_clr;
  logic          rerr;
  bit            m_err;
`endif

  int  n_tests;
  int  n_fail;
  int  m_rd;
  int  m_level;
  bit  m_empty;
  bit  m_ae;
  int  wb;

  rptr_empty #(
    .ADDRSIZE  (AW),
    .AE_THRESH (AE)
  ) dut (
    .rclk          (rclk),
    .rrst          (rrst),
`ifdef RPTR_UFLOW_EN
    .rerr_clr      (rerr_clr),
    .rerr          (rerr),
`endif
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .rlevel        (rlevel),
    .ralmost_empty (ralmost_empty)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic          rst;
    logic          inc;
    logic [AW:0]   wg;
    logic [AW-1:0] e_raddr;
    logic [AW:0]   e_rptr;
    logic          e_empty;
    logic [AW:0]   e_level;
    logic          e_ae;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [AW:0] gray5(input int b);
    logic [AW:0] v;
    v = (AW+1)'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock with model update; wbin is the write count modulo 32.
  task automatic tick(input bit rst, input bit inc, input int wbin, input bit clr);
    logic [AW:0] prev;
    bit acc;
    int d;
    prev     = rptr;
    rrst     = rst;
    rinc     = inc;
    rq2_wptr = gray5(wbin);
`ifdef RPTR_UFLOW_EN
    rerr_clr = clr;
    if (rst) m_err = 1'b0;
    else if (inc && m_empty) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
`endif
    @(posedge rclk);
    acc = !rst && inc && !m_empty;
    if (rst) begin
      m_rd = 0; m_empty = 1'b1; m_level = 0; m_ae = 1'b1;
    end else begin
      m_rd    = (m_rd + int'(acc)) % 32;
      d       = (wbin - m_rd + 32) % 32;
      m_level = (d > DEPTH) ? DEPTH : d;
      m_empty = (d == 0);
      m_ae    = (m_level <= AE);
    end
    #1;
    check("raddr", 32'(raddr), 32'(m_rd % DEPTH));
    check("rptr", 32'(rptr), 32'(gray5(m_rd)));
    check("rempty", 32'(rempty), 32'(m_empty));
    check("rlevel", 32'(rlevel), 32'(m_level));
    check("ralmost_empty", 32'(ralmost_empty), 32'(m_ae));
    if (!rst) check("gray_step", 32'($countones(prev ^ rptr)), acc ? 32'd1 : 32'd0);
`ifdef RPTR_UFLOW_EN
    check("rerr", 32'(rerr), 32'(m_err));
`endif
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    m_rd     = 0;
    m_level  = 0;
    m_empty  = 1'b1;
    m_ae     = 1'b1;
    wb       = 0;
    rrst     = 1'b1;
    rinc     = 1'b1;
    rq2_wptr = '0;
`ifdef RPTR_UFLOW_EN
    rerr_clr = 1'b0;
    m_err    = 1'b0;
`endif

    // reset, small fill of 3 words, drain, read-while-empty, reset with non-zero wptr
    vecs[0] = '{1'b1, 1'b1, 5'b00000, 4'd0, 5'b00000, 1'b1, 5'd0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 5'b00000, 4'd0, 5'b00000, 1'b1, 5'd0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 5'b00010, 4'd0, 5'b00000, 1'b0, 5'd3, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 5'b00010, 4'd1, 5'b00001, 1'b0, 5'd2, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 5'b00010, 4'd2, 5'b00011, 1'b0, 5'd1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1, 5'd0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1, 5'd0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 5'b00010, 4'd0, 5'b00000, 1'b1, 5'd0, 1'b1};

    for (int i = 0; i < 8; i++) begin
      rrst     = vecs[i].rst;
      rinc     = vecs[i].inc;
      rq2_wptr = vecs[i].wg;
      @(posedge rclk);
      #1;
      check($sformatf("vec%0d.raddr", i), 32'(raddr), 32'(vecs[i].e_raddr));
      check($sformatf("vec%0d.rptr", i), 32'(rptr), 32'(vecs[i].e_rptr));
      check($sformatf("vec%0d.rempty", i), 32'(rempty), 32'(vecs[i].e_empty));
      check($sformatf("vec%0d.rlevel", i), 32'(rlevel), 32'(vecs[i].e_level));
      check($sformatf("vec%0d.ae", i), 32'(ralmost_empty), 32'(vecs[i].e_ae));
    end

    // Full FIFO: 16 words, read all, raddr wraps 15->0
    tick(1'b1, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b0, 16, 1'b0);
    check("full.rlevel", 32'(rlevel), 32'd16);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 16, 1'b0);
    check("full.rptr", 32'(rptr), 32'b11000);
    check("full.raddr", 32'(raddr), 32'd0);
    check("full.rempty", 32'(rempty), 32'd1);
    check("full.rlevel0", 32'(rlevel), 32'd0);

    // Pointer wrap: writer advances through 31 -> 0 while reading continuously
    wb = 16;
    for (int i = 0; i < 20; i++) begin
      wb = (wb + 1) % 32;
      tick(1'b0, 1'b1, wb, 1'b0);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, wb, 1'b0);
    check("wrap.rempty", 32'(rempty), 32'd1);
    check("wrap.rptr", 32'(rptr), 32'(gray5(4)));

    // Underflow: reads while empty leave the pointer alone
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, wb, 1'b0);
    check("uflow.raddr", 32'(raddr), 32'd4);
`ifdef RPTR_UFLOW_EN
    check("uflow.rerr_set", 32'(rerr), 32'd1);
    tick(1'b0, 1'b0, wb, 1'b1);
    check("uflow.rerr_clr", 32'(rerr), 32'd0);
    tick(1'b0, 1'b1, wb, 1'b1);
    check("uflow.rerr_wins", 32'(rerr), 32'd1);
`endif

    // Illegal synchronized pointer saturates the level
    tick(1'b1, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b0, 20, 1'b0);
    check("sat.rlevel", 32'(rlevel), 32'd16);

    // Reset mid-stream with a pending read and non-zero write pointer
    tick(1'b1, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b0, 8, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8, 1'b0);
    check("mid.rlevel", 32'(rlevel), 32'd5);
    tick(1'b1, 1'b1, 8, 1'b0);
    check("mid.rptr", 32'(rptr), 32'd0);
    check("mid.raddr", 32'(raddr), 32'd0);
    check("mid.rempty", 32'(rempty), 32'd1);
    check("mid.rlevel0", 32'(rlevel), 32'd0);
    check("mid.ae", 32'(ralmost_empty), 32'd1);

    // Randomized traffic with a legal writer that never overruns DEPTH
    tick(1'b1, 1'b0, 0, 1'b0);
    wb = 0;
    for (int n = 0; n < 600; n++) begin
      int lvl;
      int adv;
      bit rst;
      lvl = (wb - m_rd + 32) % 32;
      adv = $urandom_range(0, 2);
      if (lvl + adv > DEPTH) adv = DEPTH - lvl;
      wb  = (wb + adv) % 32;
      rst = ($urandom_range(0, 63) == 0);
      if (rst) wb = 0;
      tick(rst, 1'($urandom_range(0, 1)), wb, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
